pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer for the 16-bit five-stage pipeline.
// Drives PC/IF-ID write enables, the IF/ID flush, the ID/EX bubble and the
// back-end hold. It resolves load-use stalls, taken-branch flushes and
// multi-cycle data-memory waits, and keeps saturating stall/flush counters.
// Control outputs are purely combinational from the current state and inputs.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 2,
  parameter int WIN_W        = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [WIN_W-1:0] ifid_window,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [WIN_W-1:0] idex_window,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  // Extra flush cycles still owed after the cycle in which a branch resolves.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] remain_reg, remain_next;

  logic load_use;
  logic mem_busy;
  logic run_eval;
  logic flush_evt;
  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c, pipe_hold_c;

  // Register numbers only alias when they live in the same window.
  assign load_use = idex_memread &
                    (({idex_window, idex_rd} == {ifid_window, ifid_rs}) |
                     (ifid_uses_rt & ({idex_window, idex_rd} == {ifid_window, ifid_rt})));

  assign mem_busy = mem_req & ~mem_ack;

  // State register and remaining-flush counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= RUN;
      remain_reg <= '0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
    end
  end

  // Next-state and control decode; RUN rules are shared with the MEM_WAIT ack cycle.
  always_comb begin
    state_next    = state_reg;
    remain_next   = remain_reg;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_hold_c   = 1'b0;
    flush_evt     = 1'b0;
    run_eval      = 1'b0;

    case (state_reg)
      RUN: run_eval = 1'b1;

      MEM_WAIT: begin
        if (!mem_ack) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          pipe_hold_c  = 1'b1;
          state_next   = MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end

      LOAD_STALL: begin
        // The bubble is already in EX, so the hazard check is skipped here.
        if (mem_busy) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          pipe_hold_c  = 1'b1;
          state_next   = MEM_WAIT;
        end else begin
          state_next = RUN;
        end
      end

      FLUSH: begin
        if (mem_busy) begin
          // A memory wait abandons whatever flush cycles were left.
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          pipe_hold_c  = 1'b1;
          state_next   = MEM_WAIT;
        end else begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          if (ex_branch_taken) begin
            flush_evt   = 1'b1;
            remain_next = FLUSH_RELOAD;
            state_next  = FLUSH;
          end else begin
            remain_next = remain_reg - 3'd1;
            if (remain_reg == 3'd1) begin
              state_next = RUN;
            end
          end
        end
      end

      default: state_next = RUN;
    endcase

    if (run_eval) begin
      if (mem_busy) begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        pipe_hold_c  = 1'b1;
        state_next   = MEM_WAIT;
      end else if (ex_branch_taken) begin
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        flush_evt     = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_next  = FLUSH;
          remain_next = FLUSH_RELOAD;
        end else begin
          state_next = RUN;
        end
      end else if (load_use) begin
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        idex_bubble_c = 1'b1;
        state_next    = LOAD_STALL;
      end else begin
        state_next = RUN;
      end
    end
  end

  // While reset is held the pipeline is kept empty regardless of state.
  assign pc_write    = ~rst & pc_write_c;
  assign ifid_write  = ~rst & ifid_write_c;
  assign ifid_flush  = rst | ifid_flush_c;
  assign idex_bubble = rst | idex_bubble_c;
  assign pipe_hold   = ~rst & pipe_hold_c;
  assign state       = state_reg;

  // Counter 0 counts PC-stalled cycles, counter 1 counts taken-branch flushes.
  logic [1:0]       cnt_evt;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_evt[0] = ~pc_write_c;
  assign cnt_evt[1] = flush_evt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    // Saturating event counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (cnt_clr) begin
        cnt_reg[gi] <= '0;
      end else if (cnt_evt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  end

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-level behavioural model
// predicts every control output and counter, and literal checks pin the
// model against hand-worked scenarios.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 2;
  localparam int WIN_W = 2;
  localparam int FC    = 3;
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rd;
  logic             ifid_uses_rt, idex_memread, ex_branch_taken;
  logic [WIN_W-1:0] ifid_window, idex_window;
  logic             mem_req, mem_ack, cnt_clr;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W(REG_W), .WIN_W(WIN_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .ifid_window(ifid_window), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .idex_window(idex_window), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 running, 1 just stalled for a load, 2 waiting on memory, 3 flushing
  localparam int A_NORM = 0, A_HOLD = 1, A_BUB = 2, A_BR = 3, A_FLC = 4;
  int m_mode = 0, m_left = 0, m_stall = 0, m_flush = 0;
  int nx_mode = 0, nx_left = 0, nx_stall = 0, nx_flush = 0;
  int cyc = 0;

  always begin : compare
    int act, ld_tag, rs_tag, rt_tag;
    int e_pc, e_fl, e_bub, e_hold;
    bit lu;
    @(negedge clk);
    #2;
    cyc++;
    if (rst) begin
      chk("rst_pc_write", int'(pc_write), 0);
      chk("rst_ifid_write", int'(ifid_write), 0);
      chk("rst_ifid_flush", int'(ifid_flush), 1);
      chk("rst_idex_bubble", int'(idex_bubble), 1);
      chk("rst_pipe_hold", int'(pipe_hold), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_stall_cnt", int'(stall_cnt), 0);
      chk("rst_flush_cnt", int'(flush_cnt), 0);
      $display("cyc %0d reset", cyc);
    end else begin
      ld_tag = int'(idex_window) * 4 + int'(idex_rd);
      rs_tag = int'(ifid_window) * 4 + int'(ifid_rs);
      rt_tag = int'(ifid_window) * 4 + int'(ifid_rt);
      lu = idex_memread && ((ld_tag == rs_tag) || (ifid_uses_rt && ld_tag == rt_tag));

      if (m_mode == 2 ? !mem_ack : (mem_req && !mem_ack)) act = A_HOLD;
      else if (m_mode == 1)   act = A_NORM;
      else if (ex_branch_taken) act = A_BR;
      else if (m_mode == 3)   act = A_FLC;
      else if (lu)            act = A_BUB;
      else                    act = A_NORM;

      e_pc   = (act == A_HOLD || act == A_BUB) ? 0 : 1;
      e_fl   = (act == A_BR || act == A_FLC) ? 1 : 0;
      e_bub  = (act == A_BR || act == A_FLC || act == A_BUB) ? 1 : 0;
      e_hold = (act == A_HOLD) ? 1 : 0;

      chk("pc_write", int'(pc_write), e_pc);
      chk("ifid_write", int'(ifid_write), e_pc);
      chk("ifid_flush", int'(ifid_flush), e_fl);
      chk("idex_bubble", int'(idex_bubble), e_bub);
      chk("pipe_hold", int'(pipe_hold), e_hold);
      chk("state", int'(state), m_mode);
      chk("stall_cnt", int'(stall_cnt), m_stall);
      chk("flush_cnt", int'(flush_cnt), m_flush);
      $display("cyc %0d st=%0d pc=%0d ifw=%0d fl=%0d bub=%0d hold=%0d stall=%0d flush=%0d",
               cyc, state, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
               stall_cnt, flush_cnt);

      nx_left = m_left;
      case (act)
        A_HOLD: nx_mode = 2;
        A_BUB:  nx_mode = 1;
        A_BR: begin
          nx_left = FC - 1;
          nx_mode = (nx_left > 0) ? 3 : 0;
        end
        A_FLC: begin
          nx_left = m_left - 1;
          nx_mode = (nx_left > 0) ? 3 : 0;
        end
        default: nx_mode = 0;
      endcase
      if (cnt_clr) begin
        nx_stall = 0;
        nx_flush = 0;
      end else begin
        nx_stall = (m_stall + (e_pc == 0 ? 1 : 0) > SMAX) ? SMAX : m_stall + (e_pc == 0 ? 1 : 0);
        nx_flush = (m_flush + (act == A_BR ? 1 : 0) > SMAX) ? SMAX : m_flush + (act == A_BR ? 1 : 0);
      end
    end
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_mode = nx_mode; m_left = nx_left; m_stall = nx_stall; m_flush = nx_flush;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; ifid_window = '0;
    idex_memread = 1'b0; idex_rd = '0; idex_window = '0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic load(input int rd, input int iwin, input int rs, input int rt,
                      input bit urt, input int fwin);
    idex_memread = 1'b1;
    idex_rd      = REG_W'(rd);
    idex_window  = WIN_W'(iwin);
    ifid_rs      = REG_W'(rs);
    ifid_rt      = REG_W'(rt);
    ifid_uses_rt = urt;
    ifid_window  = WIN_W'(fwin);
  endtask

  initial begin
    rst = 1'b1; cnt_clr = 1'b0; idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // quiet pipeline
    for (int i = 0; i < 10; i++) begin
      #2 chk("idle_pc", int'(pc_write), 1); chk("idle_state", int'(state), 0);
      @(negedge clk);
    end
    #2 chk("idle_stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);

    // load-use on rs, same window
    load(2, 1, 2, 0, 1'b0, 1);
    #2 chk("lu_pc", int'(pc_write), 0); chk("lu_bubble", int'(idex_bubble), 1);
    chk("lu_state", int'(state), 0);
    @(negedge clk); idle();
    #2 chk("ls_state", int'(state), 1); chk("ls_pc", int'(pc_write), 1);
    @(negedge clk);
    #2 chk("lu_back_state", int'(state), 0); chk("lu_stall_cnt", int'(stall_cnt), 1);
    @(negedge clk);

    // different window: no hazard
    load(2, 1, 2, 0, 1'b0, 0);
    #2 chk("nw_pc", int'(pc_write), 1); chk("nw_bubble", int'(idex_bubble), 0);
    @(negedge clk); idle();
    #2 chk("nw_state", int'(state), 0); chk("nw_stall_cnt", int'(stall_cnt), 1);
    @(negedge clk);

    // hazard through rt only when rt is used
    load(3, 2, 0, 3, 1'b1, 2);
    #2 chk("rt_pc", int'(pc_write), 0);
    @(negedge clk); idle();
    #2 chk("rt_state", int'(state), 1); chk("rt_stall_cnt", int'(stall_cnt), 2);
    @(negedge clk);
    load(3, 2, 0, 3, 1'b0, 2);
    #2 chk("nort_pc", int'(pc_write), 1);
    @(negedge clk); idle();
    #2 chk("nort_stall_cnt", int'(stall_cnt), 2);
    @(negedge clk);

    // memory wait of three cycles
    mem_req = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("mw_hold", int'(pipe_hold), 1); chk("mw_pc", int'(pc_write), 0);
      chk("mw_state", int'(state), (i == 0) ? 0 : 2);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    #2 chk("ack_state", int'(state), 2); chk("ack_hold", int'(pipe_hold), 0);
    chk("ack_pc", int'(pc_write), 1);
    @(negedge clk); idle();
    #2 chk("mw_back_state", int'(state), 0); chk("mw_stall_cnt", int'(stall_cnt), 5);
    @(negedge clk);
    mem_req = 1'b1; mem_ack = 1'b1;
    #2 chk("rqack_pc", int'(pc_write), 1); chk("rqack_hold", int'(pipe_hold), 0);
    @(negedge clk); idle();
    #2 chk("rqack_state", int'(state), 0); chk("rqack_stall_cnt", int'(stall_cnt), 5);
    @(negedge clk);

    // single taken branch: three flush cycles
    ex_branch_taken = 1'b1;
    #2 chk("br_flush", int'(ifid_flush), 1); chk("br_state", int'(state), 0);
    @(negedge clk); idle();
    for (int i = 0; i < 2; i++) begin
      #2 chk("fl_flush", int'(ifid_flush), 1); chk("fl_state", int'(state), 3);
      @(negedge clk);
    end
    #2 chk("fl_done_flush", int'(ifid_flush), 0); chk("fl_done_state", int'(state), 0);
    chk("fl_flush_cnt", int'(flush_cnt), 1);
    @(negedge clk);

    // second branch in the second flush cycle extends the flush to four cycles
    ex_branch_taken = 1'b1;
    #2 chk("br2a_flush", int'(ifid_flush), 1);
    @(negedge clk);
    #2 chk("br2b_flush", int'(ifid_flush), 1); chk("br2b_state", int'(state), 3);
    @(negedge clk); idle();
    for (int i = 0; i < 2; i++) begin
      #2 chk("fl2_flush", int'(ifid_flush), 1); chk("fl2_state", int'(state), 3);
      @(negedge clk);
    end
    #2 chk("fl2_done_flush", int'(ifid_flush), 0); chk("fl2_flush_cnt", int'(flush_cnt), 3);
    @(negedge clk);

    // branch + load-use + memory wait together
    ex_branch_taken = 1'b1; load(2, 1, 2, 0, 1'b0, 1); mem_req = 1'b1; mem_ack = 1'b0;
    #2 chk("cmb_hold", int'(pipe_hold), 1); chk("cmb_flush", int'(ifid_flush), 0);
    chk("cmb_bubble", int'(idex_bubble), 0); chk("cmb_pc", int'(pc_write), 0);
    @(negedge clk);
    #2 chk("cmb_wait_state", int'(state), 2); chk("cmb_wait_hold", int'(pipe_hold), 1);
    @(negedge clk);
    mem_ack = 1'b1;
    #2 chk("cmb_ack_flush", int'(ifid_flush), 1); chk("cmb_ack_bubble", int'(idex_bubble), 1);
    chk("cmb_ack_pc", int'(pc_write), 1); chk("cmb_ack_hold", int'(pipe_hold), 0);
    @(negedge clk); idle();
    #2 chk("cmb_after_state", int'(state), 3);
    @(negedge clk);
    #2 chk("cmb_after2_state", int'(state), 3);
    @(negedge clk);
    #2 chk("cmb_end_state", int'(state), 0); chk("cmb_flush_cnt", int'(flush_cnt), 4);
    chk("cmb_stall_cnt", int'(stall_cnt), 7);
    @(negedge clk);

    // clear, then saturate the stall counter
    cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    #2 chk("clr_stall_cnt", int'(stall_cnt), 0); chk("clr_flush_cnt", int'(flush_cnt), 0);
    @(negedge clk);
    mem_req = 1'b1; mem_ack = 1'b0;
    repeat (20) @(negedge clk);
    #2 chk("sat_stall_cnt", int'(stall_cnt), 15); chk("sat_state", int'(state), 2);
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    #2 chk("sat_clr_stall_cnt", int'(stall_cnt), 0);

    // asynchronous reset mid-cycle while waiting on memory
    #1 rst = 1'b1;
    #1 chk("arst_state", int'(state), 0); chk("arst_pc", int'(pc_write), 0);
    chk("arst_ifw", int'(ifid_write), 0); chk("arst_flush", int'(ifid_flush), 1);
    chk("arst_bubble", int'(idex_bubble), 1); chk("arst_hold", int'(pipe_hold), 0);
    chk("arst_stall_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0; idle();
    #2 chk("post_rst_state", int'(state), 0); chk("post_rst_pc", int'(pc_write), 1);
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
